// File: rtl/alu_mc.sv
// alu_mc: parametrised multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle ops: ADD/SUB/AND/OR/XOR/LUI/SLL/SRL/SRA.
// Optional iterative MULU (shift-add) and DIVU (restoring). Enable them by defining ALU_MULDIV_EN.
// When that macro is undefined, opcodes 1001/1010 decode as illegal and result_hi is tied to zero.

module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             ovf,
    output logic             illegal
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] LOW_MASK = {{(WIDTH/2){1'b0}}, {(WIDTH/2){1'b1}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_LUI = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;
    localparam logic [3:0] OP_SRA = 4'b1000;

`ifdef ALU_MULDIV_EN
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [3:0] OP_MULU = 4'b1001;
    localparam logic [3:0] OP_DIVU = 4'b1010;
    localparam int CW = SW + 1;
    localparam logic [CW-1:0] COUNT_INIT = CW'(WIDTH);
`endif

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             illegal_q, illegal_d;

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] add_res;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             alu_illegal;
    logic             start_muldiv;

`ifdef ALU_MULDIV_EN
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             is_div_q, is_div_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
`endif

    // Single-cycle datapath: evaluates the live operands so the result is ready at the accepting edge
    always_comb begin
        is_sub      = (op == OP_SUB);
        b_eff       = is_sub ? ~b : b;
        add_res     = a + b_eff + {{(WIDTH-1){1'b0}}, is_sub};
        shamt       = b[SW-1:0];
        alu_res     = '0;
        alu_ovf     = 1'b0;
        alu_illegal = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                alu_res = add_res;
                alu_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (add_res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_LUI: alu_res = (a & LOW_MASK) + (b << (WIDTH/2));
            OP_SLL: alu_res = a << shamt;
            OP_SRL: alu_res = a >> shamt;
            OP_SRA: alu_res = $unsigned($signed(a) >>> shamt);
`ifdef ALU_MULDIV_EN
            OP_MULU, OP_DIVU: alu_res = '0;
`endif
            default: alu_illegal = 1'b1;
        endcase
    end

`ifdef ALU_MULDIV_EN
    assign start_muldiv = (op == OP_MULU) || (op == OP_DIVU);

    // One MULU/DIVU iteration. acc_hi/acc_lo hold {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff  = div_shift[WIDTH-1:0] - opnd_q;
        if (is_div_q) begin
            if (div_shift >= {1'b0, opnd_q}) begin
                step_hi = div_diff;
                step_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
    end
`else
    assign start_muldiv = 1'b0;
`endif

    // Control FSM: capture on accept, iterate in BUSY, hold the result registers in DONE until consumed
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        illegal_d = illegal_q;
`ifdef ALU_MULDIV_EN
        result_hi_d = result_hi_q;
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        opnd_d      = opnd_q;
        is_div_d    = is_div_q;
        count_d     = count_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (start_muldiv) begin
`ifdef ALU_MULDIV_EN
                        state_d  = S_BUSY;
                        count_d  = COUNT_INIT;
                        is_div_d = (op == OP_DIVU);
                        acc_hi_d = '0;
                        acc_lo_d = (op == OP_DIVU) ? a : b;
                        opnd_d   = (op == OP_DIVU) ? b : a;
`endif
                    end else begin
                        state_d   = S_DONE;
                        result_d  = alu_res;
                        zero_d    = (alu_res == '0);
                        ovf_d     = alu_ovf;
                        illegal_d = alu_illegal;
`ifdef ALU_MULDIV_EN
                        result_hi_d = '0;
`endif
                    end
                end
            end
`ifdef ALU_MULDIV_EN
            S_BUSY: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                count_d  = count_q - 1'b1;
                if (count_q == {{(CW-1){1'b0}}, 1'b1}) begin
                    state_d     = S_DONE;
                    result_d    = step_lo;
                    result_hi_d = step_hi;
                    zero_d      = (step_lo == '0);
                    ovf_d       = 1'b0;
                    illegal_d   = 1'b0;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers; reset discards any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
`ifdef ALU_MULDIV_EN
            result_hi_q <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            opnd_q      <= '0;
            is_div_q    <= 1'b0;
            count_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
            illegal_q <= illegal_d;
`ifdef ALU_MULDIV_EN
            result_hi_q <= result_hi_d;
            acc_hi_q    <= acc_hi_d;
            acc_lo_q    <= acc_lo_d;
            opnd_q      <= opnd_d;
            is_div_q    <= is_div_d;
            count_q     <= count_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign illegal   = illegal_q;
`ifdef ALU_MULDIV_EN
    assign result_hi = result_hi_q;
`else
    assign result_hi = '0;
`endif

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc at WIDTH = 32.
// Expectations for MULU/DIVU follow ALU_MULDIV_EN the same way the design does.

module tb_alu_mc;

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic        z;
        logic        v;
        logic        ill;
        int          lat;
    } exp_t;

    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [31:0] result_hi;
    logic        zero;
    logic        ovf;
    logic        illegal;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    alu_mc #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .ovf       (ovf),
        .illegal   (illegal)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t mk(logic [31:0] r, logic [31:0] h, logic z, logic v, logic ill, int lat);
        exp_t e;
        e.res = r; e.hi = h; e.z = z; e.v = v; e.ill = ill; e.lat = lat;
        return e;
    endfunction

    // Reference behaviour built from wide signed/unsigned arithmetic
    function automatic exp_t model(logic [3:0] o, logic [31:0] x, logic [31:0] y);
        exp_t              e;
        longint            s;
        logic [63:0]       p;
        logic signed [31:0] sx;
        e = mk('0, '0, 1'b0, 1'b0, 1'b0, 0);
        sx = x;
        case (o)
            4'd0: begin
                s = longint'($signed(x)) + longint'($signed(y));
                e.res = x + y;
                e.v = (s > MAXS) || (s < MINS);
            end
            4'd1: begin
                s = longint'($signed(x)) - longint'($signed(y));
                e.res = x - y;
                e.v = (s > MAXS) || (s < MINS);
            end
            4'd2: e.res = x & y;
            4'd3: e.res = x | y;
            4'd4: e.res = x ^ y;
            4'd5: e.res = {y[15:0], x[15:0]};
            4'd6: e.res = x << y[4:0];
            4'd7: e.res = x >> y[4:0];
            4'd8: e.res = sx >>> y[4:0];
`ifdef ALU_MULDIV_EN
            4'd9: begin
                p = {32'd0, x} * {32'd0, y};
                e.res = p[31:0];
                e.hi = p[63:32];
                e.lat = 32;
            end
            4'd10: begin
                if (y == 0) begin
                    e.res = '1;
                    e.hi = x;
                end else begin
                    e.res = x / y;
                    e.hi = x % y;
                end
                e.lat = 32;
            end
`endif
            default: e.ill = 1'b1;
        endcase
        e.z = (e.res == 0);
        return e;
    endfunction

    task automatic drive_op(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        op = o; a = av; b = bv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input bit scramble, output int edges, output bit ready_seen);
        edges = 0;
        ready_seen = 1'b0;
        while (!out_valid && edges < 100) begin
            if (in_ready) ready_seen = 1'b1;
            if (scramble) begin
                a = $urandom; b = $urandom; op = 4'($urandom); in_valid = 1'($urandom);
            end
            @(posedge clk); #1;
            edges++;
        end
        in_valid = 1'b0;
        if (!out_valid) begin
            errors++;
            $display("[TB] FAIL timeout: out_valid still %b after %0d cycles, required 1", out_valid, edges);
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset out_valid: got %b required 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset in_ready: got %b required 1", in_ready); end
        checks++; if (result !== 32'd0) begin errors++; $display("[TB] FAIL reset result: got %h required 0", result); end
        checks++; if (result_hi !== 32'd0) begin errors++; $display("[TB] FAIL reset result_hi: got %h required 0", result_hi); end
        checks++; if ({zero, ovf, illegal} !== 3'b000) begin errors++; $display("[TB] FAIL reset flags: got %b required 000", {zero, ovf, illegal}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_cycle();
        logic [3:0]  t_op[$];
        logic [31:0] t_a[$];
        logic [31:0] t_b[$];
        exp_t        t_exp[$];
        exp_t        e;
        int          edges;
        bit          rdy;
        t_op.push_back(4'd0); t_a.push_back(32'h7FFFFFFF); t_b.push_back(32'h1);        t_exp.push_back(mk(32'h80000000, 0, 0, 1, 0, 0));
        t_op.push_back(4'd1); t_a.push_back(32'd5);        t_b.push_back(32'd5);        t_exp.push_back(mk(32'h0, 0, 1, 0, 0, 0));
        t_op.push_back(4'd8); t_a.push_back(32'h80000010); t_b.push_back(32'd4);        t_exp.push_back(mk(32'hF8000001, 0, 0, 0, 0, 0));
        t_op.push_back(4'd7); t_a.push_back(32'h80000010); t_b.push_back(32'd36);       t_exp.push_back(mk(32'h08000001, 0, 0, 0, 0, 0));
        t_op.push_back(4'd5); t_a.push_back(32'h1234ABCD); t_b.push_back(32'h00005678); t_exp.push_back(mk(32'h5678ABCD, 0, 0, 0, 0, 0));
        t_op.push_back(4'd1); t_a.push_back(32'h80000000); t_b.push_back(32'd1);        t_exp.push_back(mk(32'h7FFFFFFF, 0, 0, 1, 0, 0));
        t_op.push_back(4'd0); t_a.push_back(32'hFFFFFFFF); t_b.push_back(32'd1);        t_exp.push_back(mk(32'h0, 0, 1, 0, 0, 0));
        t_op.push_back(4'd6); t_a.push_back(32'd1);        t_b.push_back(32'hFFFFFFFF); t_exp.push_back(mk(32'h80000000, 0, 0, 0, 0, 0));
        t_op.push_back(4'd15); t_a.push_back(32'h12345678); t_b.push_back(32'h9);       t_exp.push_back(mk(32'h0, 0, 1, 0, 1, 0));
        for (int i = 0; i < 10; i++) begin
            logic [3:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = (i < 3) ? ra : $urandom;
            t_op.push_back(ro); t_a.push_back(ra); t_b.push_back(rb); t_exp.push_back(model(ro, ra, rb));
        end
        for (int i = 0; i < t_op.size(); i++) begin
            sb_q.push_back(t_exp[i]);
            drive_op(t_op[i], t_a[i], t_b[i]);
            wait_out(1'b0, edges, rdy);
            e = sb_q.pop_front();
            checks++; if (edges !== e.lat) begin errors++; $display("[TB] FAIL sc[%0d] latency: got %0d required %0d", i, edges, e.lat); end
            checks++; if (result !== e.res) begin errors++; $display("[TB] FAIL sc[%0d] op=%0d result: got %h required %h", i, t_op[i], result, e.res); end
            checks++; if (result_hi !== e.hi) begin errors++; $display("[TB] FAIL sc[%0d] result_hi: got %h required %h", i, result_hi, e.hi); end
            checks++; if ({zero, ovf, illegal} !== {e.z, e.v, e.ill}) begin errors++; $display("[TB] FAIL sc[%0d] op=%0d flags zvi: got %b required %b", i, t_op[i], {zero, ovf, illegal}, {e.z, e.v, e.ill}); end
            consume();
            checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("[TB] FAIL sc[%0d] consume valid/ready: got %b required 01", i, {out_valid, in_ready}); end
        end
    endtask

    task automatic test_muldiv();
        logic [3:0]  t_op[$];
        logic [31:0] t_a[$];
        logic [31:0] t_b[$];
        exp_t        t_exp[$];
        exp_t        e;
        int          edges;
        bit          rdy;
`ifdef ALU_MULDIV_EN
        t_op.push_back(4'd9);  t_a.push_back(32'hFFFFFFFF); t_b.push_back(32'hFFFFFFFF); t_exp.push_back(mk(32'h00000001, 32'hFFFFFFFE, 0, 0, 0, 32));
        t_op.push_back(4'd10); t_a.push_back(32'd100);      t_b.push_back(32'd7);        t_exp.push_back(mk(32'd14, 32'd2, 0, 0, 0, 32));
        t_op.push_back(4'd10); t_a.push_back(32'd5);        t_b.push_back(32'd0);        t_exp.push_back(mk(32'hFFFFFFFF, 32'd5, 0, 0, 0, 32));
        t_op.push_back(4'd9);  t_a.push_back(32'd0);        t_b.push_back(32'h1234);     t_exp.push_back(mk(32'h0, 32'h0, 1, 0, 0, 32));
`else
        t_op.push_back(4'd9);  t_a.push_back(32'hFFFFFFFF); t_b.push_back(32'hFFFFFFFF); t_exp.push_back(mk(32'h0, 32'h0, 1, 0, 1, 0));
        t_op.push_back(4'd10); t_a.push_back(32'd100);      t_b.push_back(32'd7);        t_exp.push_back(mk(32'h0, 32'h0, 1, 0, 1, 0));
`endif
        for (int i = 0; i < 4; i++) begin
            logic [3:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = (i % 2 == 0) ? 4'd9 : 4'd10;
            ra = $urandom;
            rb = (i == 3) ? 32'($urandom_range(1, 300)) : $urandom;
            t_op.push_back(ro); t_a.push_back(ra); t_b.push_back(rb); t_exp.push_back(model(ro, ra, rb));
        end
        for (int i = 0; i < t_op.size(); i++) begin
            sb_q.push_back(t_exp[i]);
            drive_op(t_op[i], t_a[i], t_b[i]);
            checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL md[%0d] in_ready after accept: got %b required 0", i, in_ready); end
            wait_out(1'b1, edges, rdy);
            e = sb_q.pop_front();
            checks++; if (rdy !== 1'b0) begin errors++; $display("[TB] FAIL md[%0d] in_ready during busy: got %b required 0", i, rdy); end
            checks++; if (edges !== e.lat) begin errors++; $display("[TB] FAIL md[%0d] latency: got %0d required %0d", i, edges, e.lat); end
            checks++; if (result !== e.res) begin errors++; $display("[TB] FAIL md[%0d] op=%0d result: got %h required %h", i, t_op[i], result, e.res); end
            checks++; if (result_hi !== e.hi) begin errors++; $display("[TB] FAIL md[%0d] op=%0d result_hi: got %h required %h", i, t_op[i], result_hi, e.hi); end
            checks++; if ({zero, ovf, illegal} !== {e.z, e.v, e.ill}) begin errors++; $display("[TB] FAIL md[%0d] flags zvi: got %b required %b", i, {zero, ovf, illegal}, {e.z, e.v, e.ill}); end
            consume();
            checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("[TB] FAIL md[%0d] consume valid/ready: got %b required 01", i, {out_valid, in_ready}); end
        end
    endtask

    task automatic test_backpressure();
        int edges;
        bit rdy;
        drive_op(4'd4, 32'hF0F0F0F0, 32'hFFFF0000);
        wait_out(1'b0, edges, rdy);
        for (int k = 0; k < 5; k++) begin
            op = 4'd0; a = 32'd1; b = 32'd1; in_valid = (k % 2 == 0);
            checks++; if ({out_valid, in_ready, result} !== {2'b10, 32'h0F0FF0F0}) begin
                errors++; $display("[TB] FAIL hold[%0d] valid/ready/result: got %b %b %h required 1 0 0f0ff0f0", k, out_valid, in_ready, result);
            end
            checks++; if ({zero, ovf, illegal, result_hi} !== 35'd0) begin
                errors++; $display("[TB] FAIL hold[%0d] flags/hi: got %b %h required 000 0", k, {zero, ovf, illegal}, result_hi);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        consume();
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("[TB] FAIL release valid/ready: got %b required 01", {out_valid, in_ready}); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ignored pulse queued: out_valid got %b required 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        op = 4'd0; a = 32'd10; b = 32'd20;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            checks++; if ({out_valid, in_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++; $display("[TB] FAIL b2b[%0d] valid/ready: got %b required %b", k, {out_valid, in_ready}, (k % 2 == 0) ? 2'b10 : 2'b01);
            end
            if (k % 2 == 0) begin
                checks++; if (result !== 32'd30) begin errors++; $display("[TB] FAIL b2b[%0d] result: got %h required 0000001e", k, result); end
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midbusy();
        exp_t e;
        int   edges;
        bit   rdy;
        drive_op(4'd9, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (9) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("[TB] FAIL midreset valid/ready: got %b required 01", {out_valid, in_ready}); end
        checks++; if ({result, result_hi} !== 64'd0) begin errors++; $display("[TB] FAIL midreset result: got %h %h required 0 0", result_hi, result); end
        checks++; if ({zero, ovf, illegal} !== 3'b000) begin errors++; $display("[TB] FAIL midreset flags: got %b required 000", {zero, ovf, illegal}); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("[TB] FAIL after reset valid/ready: got %b required 01", {out_valid, in_ready}); end
        sb_q.push_back(mk(32'd5, 32'd0, 0, 0, 0, 0));
        drive_op(4'd0, 32'd2, 32'd3);
        wait_out(1'b0, edges, rdy);
        e = sb_q.pop_front();
        checks++; if (edges !== e.lat) begin errors++; $display("[TB] FAIL post-reset add latency: got %0d required %0d", edges, e.lat); end
        checks++; if ({result_hi, result} !== {e.hi, e.res}) begin errors++; $display("[TB] FAIL post-reset add result: got %h required %h", result, e.res); end
        checks++; if ({zero, ovf, illegal} !== {e.z, e.v, e.ill}) begin errors++; $display("[TB] FAIL post-reset add flags: got %b required %b", {zero, ovf, illegal}, {e.z, e.v, e.ill}); end
        consume();
    endtask

    // Scenario sequence
    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 4'd0; a = 32'd0; b = 32'd0;
        test_reset();
        test_single_cycle();
        test_muldiv();
        test_backpressure();
        test_back_to_back();
        test_reset_midbusy();
        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
